// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad front-end for the BCD add/subtract ALU.
// Builds two signed two-digit BCD operands from digit/operator strobes,
// registers the ALU operands and opcode, captures the ALU result one
// settle cycle after "=", and supports chaining from the last result.
// Value format: bit 8 sign, [7:4] tens BCD digit, [3:0] units BCD digit.
//
// state  | meaning
// ENTER1 | entering operand 1, display shows op1
// ENTER2 | entering operand 2, display shows op2 once a digit is entered
// EXEC   | ALU result settling, busy high, display held
// SHOW   | result captured and displayed
module calc_sequencer (
  input  logic       clk,
  input  logic       nrst,
  input  logic       digit_strobe,
  input  logic [3:0] digit,
  input  logic       op_strobe,
  input  logic       op_sub,
  input  logic       eq_strobe,
  input  logic       clr_strobe,
  input  logic [8:0] alu_result,
  output logic [8:0] alu_op1,
  output logic [8:0] alu_op2,
  output logic [2:0] alu_opcode,
  output logic [8:0] display,
  output logic       busy
);

  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b010;

  typedef enum logic [1:0] {ENTER1, ENTER2, EXEC, SHOW} state_t;

  state_t     state, state_nxt;
  logic [8:0] op1_nxt, op2_nxt, result, result_nxt, display_nxt;
  logic [2:0] opcode_nxt;
  logic       op2_seen, op2_seen_nxt;
  logic       busy_nxt;
  logic       digit_ok;

  assign digit_ok = digit_strobe && (digit <= 4'd9);

  // State and all output-facing registers; outputs never see inputs combinationally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ENTER1;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opcode <= OPC_ADD;
      result     <= '0;
      display    <= '0;
      busy       <= 1'b0;
      op2_seen   <= 1'b0;
    end else begin
      state      <= state_nxt;
      alu_op1    <= op1_nxt;
      alu_op2    <= op2_nxt;
      alu_opcode <= opcode_nxt;
      result     <= result_nxt;
      display    <= display_nxt;
      busy       <= busy_nxt;
      op2_seen   <= op2_seen_nxt;
    end
  end

  // Next-state and register updates; clr > eq > op > digit, only the top strobe acts.
  always_comb begin
    state_nxt    = state;
    op1_nxt      = alu_op1;
    op2_nxt      = alu_op2;
    opcode_nxt   = alu_opcode;
    result_nxt   = result;
    op2_seen_nxt = op2_seen;

    if (clr_strobe) begin
      state_nxt    = ENTER1;
      op1_nxt      = '0;
      op2_nxt      = '0;
      opcode_nxt   = OPC_ADD;
      result_nxt   = '0;
      op2_seen_nxt = 1'b0;
    end else begin
      case (state)
        ENTER1: begin
          if (eq_strobe) begin
            // "=" with no second operand does nothing, but still masks lower strobes
          end else if (op_strobe) begin
            opcode_nxt   = op_sub ? OPC_SUB : OPC_ADD;
            op2_nxt      = '0;
            op2_seen_nxt = 1'b0;
            state_nxt    = ENTER2;
          end else if (digit_ok && alu_op1[7:4] == 4'd0) begin
            op1_nxt = {1'b0, alu_op1[3:0], digit};
          end
        end
        ENTER2: begin
          if (eq_strobe) begin
            state_nxt = EXEC;
          end else if (op_strobe) begin
            opcode_nxt = op_sub ? OPC_SUB : OPC_ADD;
          end else if (digit_ok && alu_op2[7:4] == 4'd0) begin
            op2_nxt      = {1'b0, alu_op2[3:0], digit};
            op2_seen_nxt = 1'b1;
          end
        end
        EXEC: begin
          result_nxt = alu_result;
          state_nxt  = SHOW;
        end
        SHOW: begin
          if (eq_strobe) begin
            // repeated "=" is ignored
          end else if (op_strobe) begin
            op1_nxt      = result;
            opcode_nxt   = op_sub ? OPC_SUB : OPC_ADD;
            op2_nxt      = '0;
            op2_seen_nxt = 1'b0;
            state_nxt    = ENTER2;
          end else if (digit_ok) begin
            op1_nxt   = {5'b0, digit};
            state_nxt = ENTER1;
          end
        end
        default: state_nxt = ENTER1;
      endcase
    end
  end

  // Display and busy follow the state being entered so they are registered alongside it.
  always_comb begin
    display_nxt = display;
    busy_nxt    = (state_nxt == EXEC);
    case (state_nxt)
      ENTER1:  display_nxt = op1_nxt;
      ENTER2:  display_nxt = op2_seen_nxt ? op2_nxt : op1_nxt;
      EXEC:    display_nxt = display;
      SHOW:    display_nxt = result_nxt;
      default: display_nxt = display;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: directed keypad sequences, a behavioural
// BCD ALU, and a scoreboard of expected EXEC operands and displayed results.
module tb_calc_sequencer;

  logic       clk;
  logic       nrst;
  logic       digit_strobe;
  logic [3:0] digit;
  logic       op_strobe;
  logic       op_sub;
  logic       eq_strobe;
  logic       clr_strobe;
  logic [8:0] alu_result;
  logic [8:0] alu_op1;
  logic [8:0] alu_op2;
  logic [2:0] alu_opcode;
  logic [8:0] display;
  logic       busy;

  typedef struct {
    logic [8:0] op1;
    logic [8:0] op2;
    logic [2:0] opc;
    logic [8:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_busy = 1'b0;

  calc_sequencer dut (
    .clk          (clk),
    .nrst         (nrst),
    .digit_strobe (digit_strobe),
    .digit        (digit),
    .op_strobe    (op_strobe),
    .op_sub       (op_sub),
    .eq_strobe    (eq_strobe),
    .clr_strobe   (clr_strobe),
    .alu_result   (alu_result),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_opcode   (alu_opcode),
    .display      (display),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd_to_int(input logic [8:0] v);
    int m;
    m = int'(v[7:4]) * 10 + int'(v[3:0]);
    return v[8] ? -m : m;
  endfunction

  // Behavioural sign-magnitude BCD ALU feeding the sequencer
  always_comb begin
    int a, b, r, m;
    a = bcd_to_int(alu_op1);
    b = bcd_to_int(alu_op2);
    r = (alu_opcode == 3'b010) ? a - b : a + b;
    m = (r < 0 ? -r : r) % 100;
    alu_result = {r < 0, 4'(m / 10), 4'(m % 10)};
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks operands during EXEC and the displayed value once busy drops
  always @(negedge clk) begin
    if (busy) begin
      check("busy_one_cycle", {8'b0, prev_busy}, 9'h000);
      if (exp_q.size() == 0) begin
        check("unexpected_exec", 9'h001, 9'h000);
      end else begin
        check("exec_op1", alu_op1, exp_q[0].op1);
        check("exec_op2", alu_op2, exp_q[0].op2);
        check("exec_opcode", {6'b0, alu_opcode}, {6'b0, exp_q[0].opc});
      end
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 9'h001, 9'h000);
      end else begin
        check("result_display", display, exp_q[0].disp);
        void'(exp_q.pop_front());
      end
    end
    prev_busy = busy;
  end

  task automatic press_digit(input logic [3:0] d);
    digit_strobe = 1'b1;
    digit        = d;
    @(posedge clk); #1;
    digit_strobe = 1'b0;
  endtask

  task automatic press_op(input logic sub);
    op_strobe = 1'b1;
    op_sub    = sub;
    @(posedge clk); #1;
    op_strobe = 1'b0;
  endtask

  task automatic press_eq(input logic [8:0] o1, input logic [8:0] o2,
                          input logic [2:0] opc, input logic [8:0] disp);
    exp_t e;
    e.op1 = o1; e.op2 = o2; e.opc = opc; e.disp = disp;
    exp_q.push_back(e);
    eq_strobe = 1'b1;
    @(posedge clk); #1;
    eq_strobe = 1'b0;
  endtask

  task automatic press_clr();
    clr_strobe = 1'b1;
    @(posedge clk); #1;
    clr_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; digit_strobe = 1'b0; digit = 4'd0; op_strobe = 1'b0;
    op_sub = 1'b0; eq_strobe = 1'b0; clr_strobe = 1'b0;
    #12;
    check("rst_op1", alu_op1, 9'h000);
    check("rst_op2", alu_op2, 9'h000);
    check("rst_opcode", {6'b0, alu_opcode}, 9'h000);
    check("rst_display", display, 9'h000);
    check("rst_busy", {8'b0, busy}, 9'h000);
    nrst = 1'b1;
    @(posedge clk); #1;

    // 12 + 34 = 46
    press_digit(4'd1); press_digit(4'd2);
    check("add_op1_disp", display, 9'h012);
    press_op(1'b0);
    check("add_op_disp_holds", display, 9'h012);
    press_digit(4'd3);
    check("add_op2_first", display, 9'h003);
    press_digit(4'd4);
    press_eq(9'h012, 9'h034, 3'b000, 9'h046);
    check("add_busy", {8'b0, busy}, 9'h001);
    idle(2);
    check("add_result", display, 9'h046);

    // chain: + 5 = 51
    press_op(1'b0);
    check("chain_op1", alu_op1, 9'h046);
    check("chain_disp", display, 9'h046);
    press_digit(4'd5);
    check("chain_op2_disp", display, 9'h005);
    press_eq(9'h046, 9'h005, 3'b000, 9'h051);
    idle(2);

    // fresh: 34 - 12 = 22
    press_digit(4'd3);
    check("fresh_disp", display, 9'h003);
    press_digit(4'd4);
    press_op(1'b1);
    check("sub_opcode", {6'b0, alu_opcode}, 9'h002);
    press_digit(4'd1); press_digit(4'd2);
    press_eq(9'h034, 9'h012, 3'b010, 9'h022);
    idle(2);

    // 12 - 34 = -22
    press_digit(4'd1); press_digit(4'd2);
    press_op(1'b1);
    press_digit(4'd3); press_digit(4'd4);
    press_eq(9'h012, 9'h034, 3'b010, 9'h122);
    idle(2);
    check("neg_result", display, 9'h122);

    // entry limits
    press_clr();
    check("clr_disp", display, 9'h000);
    check("clr_op1", alu_op1, 9'h000);
    press_digit(4'd7);
    press_digit(4'hA);
    check("bad_digit", alu_op1, 9'h007);
    press_digit(4'd8); press_digit(4'd9);
    check("third_digit", alu_op1, 9'h078);
    press_op(1'b0);
    check("op_add", {6'b0, alu_opcode}, 9'h000);
    press_op(1'b1);
    check("op_repress", {6'b0, alu_opcode}, 9'h002);
    check("op_repress_disp", display, 9'h078);
    press_digit(4'd5);

    // eq with a coincident digit: digit dropped, 78 - 5 = 73
    digit_strobe = 1'b1; digit = 4'd6;
    press_eq(9'h078, 9'h005, 3'b010, 9'h073);
    digit_strobe = 1'b0;
    idle(2);
    check("coinc_result", display, 9'h073);

    // clear during EXEC discards the result
    press_digit(4'd1);
    press_op(1'b0);
    press_digit(4'd2);
    check("pre_clr_disp", display, 9'h002);
    press_eq(9'h001, 9'h002, 3'b000, 9'h000);
    press_clr();
    check("exec_clr_disp", display, 9'h000);
    check("exec_clr_busy", {8'b0, busy}, 9'h000);
    check("exec_clr_op1", alu_op1, 9'h000);
    idle(1);
    check("exec_clr_nosshow", display, 9'h000);
    press_digit(4'd5);
    check("after_clr_enter1", display, 9'h005);

    // reset during EXEC
    press_op(1'b0);
    press_digit(4'd3);
    press_eq(9'h005, 9'h003, 3'b000, 9'h000);
    @(negedge clk); #1;
    nrst = 1'b0;
    #1;
    check("async_op1", alu_op1, 9'h000);
    check("async_op2", alu_op2, 9'h000);
    check("async_opcode", {6'b0, alu_opcode}, 9'h000);
    check("async_display", display, 9'h000);
    check("async_busy", {8'b0, busy}, 9'h000);
    #2;
    nrst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_display", display, 9'h000);
    press_digit(4'd4);
    check("post_rst_enter1", display, 9'h004);
    press_digit(4'd2);
    check("post_rst_op1", alu_op1, 9'h042);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 9'(exp_q.size()), 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Front-end controller for the BCD add/subtract ALU in the calculator datapath. It collects keypad digit and operator strobes and builds two signed two-digit BCD operands. It drives the ALU's operand and opcode inputs from registers, samples the combinational result after one settle cycle, and holds it for display. It also supports chained operations, where the last result becomes the next first operand.

## Interface
- No parameters; widths are fixed by the ALU format: bit 8 is the sign, bits 7:4 are the tens BCD digit, bits 3:0 are the units BCD digit.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- digit_strobe  in  1  one-cycle pulse; digit is valid
- digit  in  4  BCD digit 0-9
- op_strobe  in  1  one-cycle pulse; op_sub is valid
- op_sub  in  1  0 = add, 1 = subtract
- eq_strobe  in  1  one-cycle pulse, "="
- clr_strobe  in  1  one-cycle pulse, clear all
- alu_result  in  9  combinational result from the ALU
- alu_op1  out  9  registered ALU operand 1
- alu_op2  out  9  registered ALU operand 2
- alu_opcode  out  3  registered; 3'b000 = add, 3'b010 = subtract
- display  out  9  value to show
- busy  out  1  high while the ALU result is settling

## Operation
- States: ENTER1, ENTER2, EXEC, SHOW. Reset state is ENTER1.
- Priority when strobes coincide in one cycle: clr > eq > op > digit. Only the highest-priority strobe acts.
- clr_strobe in any state:
  - op1, op2, result, and display go to 0; opcode goes to 3'b000.
  - Next state is ENTER1.
  - This applies in EXEC too; the in-flight result is discarded.
- Digit entry (ENTER1 targets op1, ENTER2 targets op2):
  - The target register shifts: [7:4] ← [3:0], [3:0] ← digit.
  - The target's bit 8 stays 0.
  - Digits greater than 9 are ignored.
  - A third digit when the tens digit is already nonzero is ignored; only two digits are stored.
- op_strobe in ENTER1: latch opcode from op_sub, clear op2, go to ENTER2.
- op_strobe in ENTER2: replace opcode only (the operator was re-pressed), with no computation.
- op_strobe in SHOW (chaining): op1 ← result (including the sign bit), latch opcode, clear op2, go to ENTER2.
- eq_strobe:
  - In ENTER2: go to EXEC.
  - In ENTER1 and SHOW: ignored.
- digit_strobe in SHOW: op1 ← {5'b0, digit}, go to ENTER1. This starts a fresh calculation.
- EXEC:
  - Lasts exactly one cycle. busy = 1.
  - All strobes except clr are ignored.
  - At the end of the cycle: result ← alu_result, go to SHOW.
- display:
  - ENTER1: op1.
  - ENTER2: op2 once at least one digit has been entered since the op_strobe; otherwise op1.
  - EXEC: the previous display value is held.
  - SHOW: result.
- The sign and overflow interpretation of alu_result is passed through unmodified; the sequencer does no arithmetic.

## Timing
- Reset values: alu_op1 = 0, alu_op2 = 0, alu_opcode = 3'b000, display = 0, busy = 0, state ENTER1.
- Every output is driven from a register; there are no combinational paths from inputs to outputs.
- A strobe sampled on edge N updates the registers and outputs visible after edge N.
- eq_strobe at edge N:
  - busy is high for the cycle after N.
  - result is captured at edge N+1.
  - display shows the result after edge N+1. Latency is 2 edges from the strobe.
- alu_op1, alu_op2, and alu_opcode are stable for at least the whole EXEC cycle.
- Strobes that arrive while busy are dropped, not queued. The clear strobe is the only exception.
- Asserting nrst in any state, including EXEC, forces reset values immediately. No capture occurs.

## Test plan
- Add: reset; press 1, 2, +, 3, 4, =. Required: busy high for 1 cycle, then display = 9'h046 and state SHOW.
- Subtract: press 3, 4, −, 1, 2, =. Required: alu_opcode = 3'b010 during EXEC and display = 9'h022. Then 1, 2, −, 3, 4, =. Required: display = alu_result = 9'h122.
- Chain: after 12 + 34 = (display 9'h046), press +, 5, =. Required: alu_op1 = 9'h046, alu_op2 = 9'h005, display = 9'h051.
- Entry limits: press 7, 8, 9. Required: op1 = 9'h078. Digit 4'hA is ignored. In ENTER2, an op_strobe with op_sub = 1 changes alu_opcode to 3'b010 and does not change display.
- Coincident strobes and clear: eq_strobe together with digit_strobe in ENTER2 → EXEC, with the digit dropped. clr_strobe during EXEC → ENTER1 on the next cycle, display = 0, and the result is never shown.
- Reset mid-operation: deassert nrst during EXEC. Required: all outputs are 0 at once, asynchronously before the next edge; after release the state is ENTER1.
